// File: rtl/hamming_secded_stream_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming_pkg                                                              |
// | Shared helpers for the parametrised Hamming SECDED codec: parity-width   |
// | derivation, codeword position mapping and error-class encodings.         |
// | Revision: 1.0 - initial parametrised release                             |
// +--------------------------------------------------------------------------+
package hamming_pkg;

  // Error classes reported by the decoder.
  localparam logic [1:0] CLEAN  = 2'd0;
  localparam logic [1:0] SINGLE = 2'd1;
  localparam logic [1:0] DOUBLE = 2'd2;

  // Smallest R such that 2^R >= data_w + R + 1.
  function automatic int par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r = r + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Code position (1-based) of data bit i: the (i+1)-th non-power-of-two.
  function automatic int data_pos(input int i);
    int pos;
    int seen;
    pos  = 0;
    seen = 0;
    while (seen <= i) begin
      pos = pos + 1;
      if (!is_pow2(pos)) seen = seen + 1;
    end
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_secded_stream_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming_secded_stream_decoder_if                                         |
// | Stream bundle of the SECDED decoder: codeword input (s_*, correct_en)    |
// | and decoded-word output (m_*).                                           |
// |   slave  : decoder side (consumes codewords, produces decoded words)     |
// |   master : environment side (deframer source + FIFO sink)                |
// | Revision: 1.0 - initial parametrised release                             |
// +--------------------------------------------------------------------------+
interface hamming_secded_stream_decoder_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAR_W  = par_w(DATA_W),
  parameter int CODE_W = DATA_W + PAR_W + 1
) ();

  logic              s_valid;
  logic              s_ready;
  logic [CODE_W-1:0] s_code;
  logic              correct_en;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_single;
  logic              m_double;
  logic [PAR_W-1:0]  m_syndrome;

  modport slave (
    input  s_valid, s_code, correct_en, m_ready,
    output s_ready, m_valid, m_data, m_single, m_double, m_syndrome
  );

  modport master (
    output s_valid, s_code, correct_en, m_ready,
    input  s_ready, m_valid, m_data, m_single, m_double, m_syndrome
  );

endinterface
`default_nettype wire

// File: rtl/hamming_secded_stream_decoder_syndrome.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming_syndrome                                                         |
// | Combinational syndrome and overall-parity computation.                   |
// |   code     in  CODE_W : received codeword (position p at code[p-1])      |
// |   syndrome out PAR_W  : bit k = XOR of positions with index bit k set    |
// |   ov       out 1      : XOR of all CODE_W bits                            |
// | Revision: 1.0 - initial parametrised release                             |
// +--------------------------------------------------------------------------+
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAR_W  = par_w(DATA_W),
  parameter int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [PAR_W-1:0]  syndrome,
  output logic              ov
);

  localparam int N = DATA_W + PAR_W;

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < PAR_W; k++) begin
      for (int p = 1; p <= N; p++) begin
        if (((p >> k) & 1) == 1) syndrome[k] = syndrome[k] ^ code[p-1];
      end
    end
    ov = ^code;
  end

endmodule
`default_nettype wire

// File: rtl/hamming_secded_stream_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming_secded_stream_decoder                                            |
// | Two-stage pipelined Hamming SECDED decoder with valid/ready streaming,   |
// | runtime detect-only mode and saturating error counters.                  |
// |   clk, rst_n   : clock (rising edge), async active-low reset             |
// |   bus (slave)  : s_valid/s_ready/s_code/correct_en in,                   |
// |                  m_valid/m_ready/m_data/m_single/m_double/m_syndrome out |
// |   cnt_clr      : synchronous clear of both counters (beats increments)   |
// |   sec_cnt      : saturating count of delivered words with m_single       |
// |   ded_cnt      : saturating count of delivered words with m_double       |
// | Revision: 1.0 - initial parametrised release                             |
// +--------------------------------------------------------------------------+
module hamming_secded_stream_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAR_W  = par_w(DATA_W),
  parameter int CODE_W = DATA_W + PAR_W + 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_secded_stream_decoder_if.slave bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      sec_cnt,
  output logic [CNT_W-1:0]      ded_cnt
);

  localparam int               N       = DATA_W + PAR_W;
  localparam logic [PAR_W-1:0] N_SYN   = PAR_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Global advance: both stages move together, so bubbles are kept.
  logic en;
  assign en          = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = en;

  // Stage 1 combinational syndrome
  logic [PAR_W-1:0] syn_w;
  logic             ov_w;

  hamming_syndrome #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .CODE_W (CODE_W)
  ) u_syndrome (
    .code     (bus.s_code),
    .syndrome (syn_w),
    .ov       (ov_w)
  );

  // Stage 1 registers
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_ov;
  logic              s1_cen;

  // Stage 2 classification
  logic [1:0]        err_class;
  logic              flip;
  logic [DATA_W-1:0] corr_data;

  always_comb begin
    err_class = CLEAN;
    flip      = 1'b0;
    if (s1_syn == '0) begin
      err_class = s1_ov ? SINGLE : CLEAN;
    end else if (!s1_ov || (s1_syn > N_SYN)) begin
      // Even error count, or an odd count that points outside the word.
      err_class = DOUBLE;
    end else begin
      err_class = SINGLE;
      flip      = s1_cen;
    end
  end

  // A flipped parity position never reaches the data, so correction only
  // needs to be applied on the data positions.
  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    localparam int POS = data_pos(i);
    assign corr_data[i] = s1_code[POS-1] ^ (flip && (s1_syn == PAR_W'(POS)));
  end

  // Parity positions and the overall bit are only consumed by the syndrome.
  logic unused_code_bits;
  assign unused_code_bits = ^s1_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_code        <= '0;
      s1_syn         <= '0;
      s1_ov          <= 1'b0;
      s1_cen         <= 1'b0;
      bus.m_valid    <= 1'b0;
      bus.m_data     <= '0;
      bus.m_single   <= 1'b0;
      bus.m_double   <= 1'b0;
      bus.m_syndrome <= '0;
    end else if (en) begin
      s1_valid    <= bus.s_valid;
      bus.m_valid <= s1_valid;
      if (bus.s_valid) begin
        s1_code <= bus.s_code;
        s1_syn  <= syn_w;
        s1_ov   <= ov_w;
        s1_cen  <= bus.correct_en;
      end
      if (s1_valid) begin
        bus.m_data     <= corr_data;
        bus.m_single   <= (err_class == SINGLE);
        bus.m_double   <= (err_class == DOUBLE);
        bus.m_syndrome <= s1_syn;
      end
    end
  end

  // Counters track words as they leave the block.
  logic xfer;
  assign xfer = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (xfer) begin
      if (bus.m_single && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + 1'b1;
      if (bus.m_double && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_stream_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hamming_secded_stream_decoder                                         |
// | Scoreboard bench: the driver pushes reference-model results for every   |
// | accepted codeword; an independent monitor pops and compares on each     |
// | output transfer, and tracks counters, hold stability and s_ready.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hamming_secded_stream_decoder;

  localparam int DATA_W = 8;
  localparam int PAR_W  = 4;
  localparam int CODE_W = 13;
  localparam int CNT_W  = 2;
  localparam int N      = 12;
  localparam int CMAX   = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              single;
    logic              dbl;
    logic [PAR_W-1:0]  syn;
    int                cyc;
    bit                lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  hamming_secded_stream_decoder_if #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CODE_W(CODE_W)) bus ();

  hamming_secded_stream_decoder #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W),
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .cnt_clr (cnt_clr),
    .sec_cnt (sec_cnt),
    .ded_cnt (ded_cnt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit isp2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int p;
    int s;
    c = '0;
    p = 1;
    s = 0;
    for (int i = 0; i < DATA_W; i++) begin
      while (isp2(p)) p++;
      c[p-1] = d[i];
      p++;
    end
    for (int k = 1; k <= N; k++) if (c[k-1]) s = s ^ k;
    for (int k = 0; k < PAR_W; k++) if (s[k]) c[(1 << k) - 1] = 1'b1;
    c[N] = ^c[N-1:0];
    return c;
  endfunction

  function automatic exp_t model(input logic [CODE_W-1:0] code, input bit cen);
    exp_t e;
    logic [CODE_W-1:0] c;
    int s;
    int p;
    bit ov;
    c = code;
    s = 0;
    for (int k = 1; k <= N; k++) if (c[k-1]) s = s ^ k;
    ov = ^c;
    e.syn    = s[PAR_W-1:0];
    e.single = 1'b0;
    e.dbl    = 1'b0;
    if (s == 0) e.single = ov;
    else if (!ov || s > N) e.dbl = 1'b1;
    else begin
      e.single = 1'b1;
      if (cen) c[s-1] = ~c[s-1];
    end
    p = 1;
    for (int i = 0; i < DATA_W; i++) begin
      while (isp2(p)) p++;
      e.data[i] = c[p-1];
      p++;
    end
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle1(input bit v, input logic [CODE_W-1:0] code, input bit cen,
                        input bit rdy, input bit clr, input bit lat, output bit acc);
    exp_t e;
    bus.s_valid    = v;
    bus.s_code     = code;
    bus.correct_en = cen;
    bus.m_ready    = rdy;
    cnt_clr        = clr;
    @(negedge clk);
    acc = v && (rst_n === 1'b1) && (bus.s_ready === 1'b1);
    if (acc) begin
      e     = model(code, cen);
      e.cyc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) cycle1(1'b0, '0, 1'b0, rdy, 1'b0, 1'b0, acc);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_m_valid"},    32'(bus.m_valid), 32'd0);
    check({tag, "_m_data"},     32'(bus.m_data), 32'd0);
    check({tag, "_m_single"},   32'(bus.m_single), 32'd0);
    check({tag, "_m_double"},   32'(bus.m_double), 32'd0);
    check({tag, "_m_syndrome"}, 32'(bus.m_syndrome), 32'd0);
    check({tag, "_sec_cnt"},    32'(sec_cnt), 32'd0);
    check({tag, "_ded_cnt"},    32'(ded_cnt), 32'd0);
    check({tag, "_s_ready"},    32'(bus.s_ready), 32'd1);
  endtask

  // ---------------- monitor ----------------
  function automatic logic [31:0] payload();
    return 32'({bus.m_data, bus.m_single, bus.m_double, bus.m_syndrome});
  endfunction

  int          m_sec = 0;
  int          m_ded = 0;
  bit          held = 1'b0;
  logic [31:0] held_pl = '0;

  always @(negedge clk) begin
    exp_t e;
    bit   got;
    if (rst_n !== 1'b1) begin
      q.delete();
      held  = 1'b0;
      m_sec = 0;
      m_ded = 0;
    end else begin
      got = 1'b0;
      check("sec_cnt", 32'(sec_cnt), 32'(m_sec));
      check("ded_cnt", 32'(ded_cnt), 32'(m_ded));
      check("s_ready", 32'(bus.s_ready), 32'(!bus.m_valid || bus.m_ready));
      if (held) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_payload", payload(), held_pl);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(bus.m_valid), 32'd0);
        end else begin
          e   = q.pop_front();
          got = 1'b1;
          check("m_data",     32'(bus.m_data), 32'(e.data));
          check("m_single",   32'(bus.m_single), 32'(e.single));
          check("m_double",   32'(bus.m_double), 32'(e.dbl));
          check("m_syndrome", 32'(bus.m_syndrome), 32'(e.syn));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      held    = bus.m_valid && !bus.m_ready;
      held_pl = payload();
      if (cnt_clr) begin
        m_sec = 0;
        m_ded = 0;
      end else if (got) begin
        if (e.single && m_sec < CMAX) m_sec++;
        if (e.dbl && m_ded < CMAX) m_ded++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [CODE_W-1:0] dir_codes [6] = '{13'h0A27, 13'h0A07, 13'h0A07, 13'h1A27, 13'h0A24, 13'h0AAE};
  bit                dir_cen   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    bit                acc;
    int                idx;
    int                guard;
    logic [CODE_W-1:0] w [4];
    logic [CODE_W-1:0] pend;
    bit                have;
    bit                pcen;

    bus.s_valid    = 1'b0;
    bus.s_code     = '0;
    bus.correct_en = 1'b0;
    bus.m_ready    = 1'b0;
    cnt_clr        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst_n = 1'b1;

    // Directed words from the test plan, back to back with m_ready high
    for (int i = 0; i < 6; i++) cycle1(1'b1, dir_codes[i], dir_cen[i], 1'b1, 1'b0, 1'b1, acc);
    idle(4, 1'b1);

    // Clear alone
    cycle1(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    idle(1, 1'b1);

    // Backpressure: 4 words, m_ready low for 3 cycles mid-stream
    for (int i = 0; i < 4; i++) w[i] = encode(8'($urandom)) ^ (13'd1 << (i * 3));
    idx   = 0;
    guard = 0;
    while (idx < 4 && guard < 40) begin
      cycle1(1'b1, w[idx], 1'b1, !(guard >= 2 && guard < 5), 1'b0, 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    if (idx < 4) check("bp_send_timeout", 32'(idx), 32'd4);
    idle(4, 1'b1);

    // cnt_clr coinciding with an error transfer
    cycle1(1'b1, 13'h0A07, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    idle(3, 1'b1);
    cycle1(1'b1, 13'h0A07, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    cycle1(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    idle(1, 1'b1);
    check("clr_priority_sec", 32'(sec_cnt), 32'd0);

    // Five single-error words saturate a 2-bit counter
    for (int i = 0; i < 5; i++)
      cycle1(1'b1, encode(8'($urandom)) ^ (13'd1 << $urandom_range(0, CODE_W - 1)),
             1'($urandom), 1'b1, 1'b0, 1'b1, acc);
    idle(4, 1'b1);
    check("sec_saturate", 32'(sec_cnt), 32'd3);

    // Reset with words in flight
    cycle1(1'b1, encode(8'h3C), 1'b1, 1'b0, 1'b0, 1'b0, acc);
    cycle1(1'b1, encode(8'hC3), 1'b1, 1'b0, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3, 1'b1);

    // Randomised traffic; an unaccepted word is held until taken
    have = 1'b0;
    pend = '0;
    pcen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!have && ($urandom % 5 != 0)) begin
        pend = encode(8'($urandom));
        for (int k = 0; k < int'($urandom % 4); k++) pend[$urandom_range(0, CODE_W - 1)] ^= 1'b1;
        pcen = 1'($urandom);
        have = 1'b1;
      end
      cycle1(have, pend, pcen, ($urandom % 4 != 0), ($urandom % 40 == 0), 1'b0, acc);
      if (acc) have = 1'b0;
    end

    // Drain
    guard = 0;
    while (q.size() != 0 && guard < 30) begin
      idle(1, 1'b1);
      guard++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    idle(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_secded_stream_decoder.md
# hamming_secded_stream_decoder

Parametrised, pipelined Hamming SECDED decoder for the UART receive path. It generalises the fixed (13,8) decoder to any data width. It adds a valid/ready stream interface, a registered two-stage pipeline, a runtime detect-only mode, out-of-range syndrome detection and saturating error counters. It sits between the UART deframer (codeword source) and the receive FIFO (data sink).

## Interface
- `DATA_W`, default 8: data bits per codeword, ≥ 4.
- `PAR_W`, default derived: Hamming parity bits. Smallest R with 2^R ≥ DATA_W+R+1; equals 4 for DATA_W=8.
- `CODE_W`, default DATA_W+PAR_W+1: codeword width, including the overall parity bit.
- `CNT_W`, default 16: width of each error counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_valid` in 1: input codeword valid.
- `s_ready` out 1: decoder can accept a codeword.
- `s_code` in CODE_W: received codeword.
- `correct_en` in 1: 1 = correct single errors; 0 = detect only.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: sink accepts the output word.
- `m_data` out DATA_W: decoded data.
- `m_single` out 1: a single error was found. It was corrected if `correct_en` was set.
- `m_double` out 1: uncorrectable error. Covers both a double error and an out-of-range syndrome.
- `m_syndrome` out PAR_W: raw syndrome of the word.
- `cnt_clr` in 1: synchronous clear of both counters.
- `sec_cnt` out CNT_W: saturating count of words with `m_single` set.
- `ded_cnt` out CNT_W: saturating count of words with `m_double` set.

## Operation
**Codeword layout**
- Positions 1..N are stored in `code[pos-1]`, with N = DATA_W+PAR_W.
- Parity bits sit at power-of-two positions.
- Data bits fill the remaining positions in ascending order, starting with `data[0]`.
- `code[N]` holds the overall even parity over all CODE_W bits.
- For DATA_W=8 this is exactly the existing (13,8) map.

**Syndrome and overall parity**
- Syndrome bit k = XOR of every position whose index has bit k set (the parity bit included).
- `ov` = XOR of all CODE_W bits.

**Classification** (S = syndrome)
- S=0, ov=0: clean. Flags are 0.
- S=0, ov=1: the overall parity bit is in error. `m_single`=1. Data is unaffected.
- S in 1..N, ov=1: single error. `m_single`=1.
  - If `correct_en`=1, flip position S before extracting data.
  - If `correct_en`=0, data is passed through uncorrected.
- S≠0, ov=0: `m_double`=1. Data is raw (uncorrected).
- S>N, ov=1: out-of-range syndrome (odd multi-bit error). `m_double`=1, `m_single`=0. Data is raw.
- `m_single` and `m_double` are never both 1.

**Sampling**
- `correct_en` is sampled together with the codeword in stage 1, so it is carried per word.

**Counters**
- A counter increments when the corresponding flag leaves the block, i.e. on an `m_valid && m_ready` transfer.
- Counters saturate at all-ones.
- `cnt_clr` has priority over an increment in the same cycle.

## Timing
**Pipeline**
- Stage 1 registers the codeword, syndrome, `ov` and the sampled `correct_en`.
- Stage 2 registers corrected data and flags onto the `m_*` outputs.
- Latency: 2 cycles from an accepted `s_valid && s_ready` to `m_valid`.
- Throughput: 1 word per cycle.

**Handshake**
- Global advance enable: `en = !m_valid || m_ready`. `s_ready = en`.
- With `en` low, both stages hold. Bubbles are not squeezed out.
- Once `m_valid` is high, `m_data`, the flags and `m_syndrome` stay stable until the word is accepted.
- `m_valid` must not depend combinationally on `m_ready`. `s_ready` depends combinationally only on `m_valid` and `m_ready`.

**Reset**
- Asynchronous assertion of `rst_n` clears both stage valid bits and all outputs to 0: `m_valid`, `m_data`, `m_single`, `m_double`, `m_syndrome`, `sec_cnt`, `ded_cnt`.
- A reset mid-stream drops any in-flight words.
- `s_ready` goes to 1 while `rst_n` is low.

## Structure
- Shared package `hamming_pkg` holds:
  - `function par_w(data_w)`;
  - `function is_pow2(pos)`;
  - `function data_pos(i)`, returning the code position of data bit i;
  - the error-class localparams CLEAN/SINGLE/DOUBLE.
- The future parametrised encoder uses the same package.
- One sub-module is natural: `hamming_syndrome` (combinational: code → syndrome, ov), instantiated in stage 1.

## Test plan
All scenarios use DATA_W=8 and 0xA5, whose clean codeword is 0x0A27.
- Reset: with `rst_n`=0, all outputs are 0 and `s_ready`=1. After release, 0x0A27 in → 2 cycles later `m_data`=0xA5, flags 0, `m_syndrome`=0.
- Single data-bit error, correcting:
  - 0x0A07 (bit5 flipped), `correct_en`=1 → `m_data`=0xA5, `m_single`=1, `m_syndrome`=6, `sec_cnt`=1.
  - Same word with `correct_en`=0 → `m_data`=0xA1, `m_single`=1.
- Overall-parity-bit error: 0x1A27 → `m_data`=0xA5, `m_single`=1, `m_syndrome`=0.
- Double error and out-of-range syndrome:
  - 0x0A24 (bits 0,1 flipped) → `m_double`=1, `m_syndrome`=3, `ded_cnt`=1.
  - 0x0AAE (positions 1,4,8 flipped) → `m_double`=1, `m_syndrome`=13.
- Backpressure: stream 4 words with `m_ready` held 0 for 3 cycles → `s_ready`=0 while stalled, outputs stable, all 4 delivered in order, no loss or duplication.
- Counters:
  - CNT_W=2, five single-error words → `sec_cnt` saturates at 3.
  - `cnt_clr` coinciding with an error transfer → 0.
